// File: rtl/g31_sha256_ctrl_if.sv
// g31_sha256_ctrl_if
// Avalon-MM slave bundle between the HPS lightweight bridge and the SHA-256
// sequencer register file.
//   avs_address   : word address (5 bits)
//   avs_write     : write strobe, avs_writedata sampled on the same edge
//   avs_read      : read strobe, avs_readdata valid one cycle later
//   avs_readdata  : registered read data
// Modports: master (bridge side) and slave (register file side).
interface g31_sha256_ctrl_if;
  logic [4:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/g31_sha256_ctrl.sv
// g31_sha256_ctrl
// Sequencer for the SHA-256 compression datapath (g31_sha256_core). Holds one
// 16-word message block written over Avalon-MM and walks the datapath through
// INIT -> LOAD -> ROUNDS x ROUND -> UPDATE, reporting busy/done/overrun, a
// processed-block counter and a level interrupt.
//
// Ports:
//   clk_clk       : system clock
//   reset_reset   : asynchronous active-high reset
//   avs           : Avalon-MM slave (g31_sha256_ctrl_if.slave)
//   irq           : level interrupt, registered done & irq_en
//   core_init     : 1-cycle pulse, datapath loads the FIPS IV (only if init_iv)
//   core_load     : 1-cycle pulse, working vars <= H0..H7
//   core_round_en : high for ROUNDS cycles
//   core_t        : round index, 0 outside ROUND
//   core_msg      : M[core_t[3:0]] straight from the buffer
//   core_update   : 1-cycle pulse, H[i] += working var
//   core_hash     : H0 in [255:224] down to H7 in [31:0]
//   dbg_led       : (G31_SHA_CTRL_DEBUG_EN only) {state, core_t, busy}, registered
//
// Register map (word addresses):
//   0x00-0x0F M0..M15 (rw, writes while busy are dropped and flag overrun)
//   0x10 CTRL   bit0 start (W1 pulse, reads 0), bit1 init_iv, bit2 irq_en
//   0x11 STATUS bit0 busy, bit1 done (W1C), bit2 overrun (W1C), [15:8] blkcnt,
//               [31:24] ignored-start count with G31_SHA_CTRL_DEBUG_EN, else 0
//   0x18-0x1F H0..H7 from core_hash
//
// Optional feature macro: G31_SHA_CTRL_DEBUG_EN
module g31_sha256_ctrl #(
  parameter int ROUNDS   = 64,
  parameter int BLKCNT_W = 8
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  g31_sha256_ctrl_if.slave      avs,
  output logic                  irq,
  output logic                  core_init,
  output logic                  core_load,
  output logic                  core_round_en,
  output logic [5:0]            core_t,
  output logic [31:0]           core_msg,
  output logic                  core_update,
  input  logic [255:0]          core_hash
`ifdef G31_SHA_CTRL_DEBUG_EN
  ,
  output logic [9:0]            dbg_led
`endif
);

  localparam int T_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  // State encodings double as the debug state codes.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;

  logic [2:0]          state_reg, state_next;
  logic [T_W-1:0]      t_reg, t_next;
  logic                init_iv_reg;
  logic                irq_en_reg;
  logic                done_reg;
  logic                overrun_reg;
  logic                irq_reg;
  logic [BLKCNT_W-1:0] blkcnt_reg;
  logic [31:0]         rdata_reg;
  logic [31:0]         rdata_next;
  logic [7:0]          ign_byte;

  logic [31:0] m_word [16];
  logic [31:0] h_word [8];

  logic busy;
  logic wr_msg, wr_ctrl, wr_status;
  logic start_req, start_ok, overrun_set;

  assign busy        = (state_reg != S_IDLE);
  assign wr_msg      = avs.avs_write && (avs.avs_address[4] == 1'b0);
  assign wr_ctrl     = avs.avs_write && (avs.avs_address == 5'h10);
  assign wr_status   = avs.avs_write && (avs.avs_address == 5'h11);
  assign start_req   = wr_ctrl && avs.avs_writedata[0];
  assign start_ok    = start_req && !busy;
  // Both a start and a buffer write during a block would corrupt the run,
  // so they are dropped and remembered.
  assign overrun_set = busy && (start_req || wr_msg);

  // Message buffer: one register per word so the reset can clear all of it.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_msg
      logic [31:0] word_reg;
      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
          word_reg <= '0;
        end else if (wr_msg && !busy && (avs.avs_address[3:0] == 4'(gi))) begin
          word_reg <= avs.avs_writedata;
        end
      end
      assign m_word[gi] = word_reg;
    end

    for (gi = 0; gi < 8; gi++) begin : g_hash
      assign h_word[gi] = core_hash[255 - 32*gi -: 32];
    end
  endgenerate

  // Sequencer next-state logic.
  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    case (state_reg)
      S_IDLE:   if (start_ok) state_next = S_INIT;
      S_INIT:   state_next = S_LOAD;
      S_LOAD: begin
        state_next = S_ROUND;
        t_next     = '0;
      end
      S_ROUND: begin
        if (t_reg == T_W'(ROUNDS - 1)) begin
          state_next = S_UPDATE;
          t_next     = '0;
        end else begin
          t_next = t_reg + T_W'(1);
        end
      end
      S_UPDATE: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath controls decode straight from state so a reset drops them at once.
  assign core_init     = (state_reg == S_INIT) && init_iv_reg;
  assign core_load     = (state_reg == S_LOAD);
  assign core_round_en = (state_reg == S_ROUND);
  assign core_update   = (state_reg == S_UPDATE);
  assign core_t        = (state_reg == S_ROUND) ? 6'(t_reg) : 6'd0;
  assign core_msg      = m_word[core_t[3:0]];
  assign irq           = irq_reg;

`ifdef G31_SHA_CTRL_DEBUG_EN
  logic [7:0] ign_cnt_reg;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ign_cnt_reg <= '0;
      dbg_led     <= '0;
    end else begin
      if (start_req && busy && (ign_cnt_reg != 8'hFF)) begin
        ign_cnt_reg <= ign_cnt_reg + 8'd1;
      end
      dbg_led <= {state_reg, core_t, busy};
    end
  end

  assign ign_byte = ign_cnt_reg;
`else
  assign ign_byte = 8'h00;
`endif

  // Read mux, registered below only when avs_read is high.
  always_comb begin
    rdata_next = '0;
    if (avs.avs_address[4] == 1'b0) begin
      rdata_next = m_word[avs.avs_address[3:0]];
    end else if (avs.avs_address == 5'h10) begin
      rdata_next = {29'd0, irq_en_reg, init_iv_reg, 1'b0};
    end else if (avs.avs_address == 5'h11) begin
      rdata_next = {ign_byte, 8'd0, 8'(blkcnt_reg), 5'd0, overrun_reg, done_reg, busy};
    end else if (avs.avs_address[4:3] == 2'b11) begin
      rdata_next = h_word[avs.avs_address[2:0]];
    end
  end

  assign avs.avs_readdata = rdata_reg;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_reg   <= S_IDLE;
      t_reg       <= '0;
      init_iv_reg <= 1'b0;
      irq_en_reg  <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      irq_reg     <= 1'b0;
      blkcnt_reg  <= '0;
      rdata_reg   <= '0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;

      if (wr_ctrl) begin
        init_iv_reg <= avs.avs_writedata[1];
        irq_en_reg  <= avs.avs_writedata[2];
      end

      // A fresh IV starts a new message, so the block count restarts too.
      if (state_reg == S_UPDATE) begin
        blkcnt_reg <= blkcnt_reg + BLKCNT_W'(1);
      end else if (start_ok && avs.avs_writedata[1]) begin
        blkcnt_reg <= '0;
      end

      // Setting beats a same-cycle W1C so a completion is never lost.
      if (state_reg == S_UPDATE) begin
        done_reg <= 1'b1;
      end else if (wr_status && avs.avs_writedata[1]) begin
        done_reg <= 1'b0;
      end

      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end else if (wr_status && avs.avs_writedata[2]) begin
        overrun_reg <= 1'b0;
      end

      irq_reg <= done_reg && irq_en_reg;

      if (avs.avs_read) begin
        rdata_reg <= rdata_next;
      end
    end
  end

endmodule

// File: tb/tb_g31_sha256_ctrl.sv
module tb_g31_sha256_ctrl;

  logic         clk_clk = 1'b0;
  logic         reset_reset;
  logic         irq;
  logic         core_init, core_load, core_round_en, core_update;
  logic [5:0]   core_t;
  logic [31:0]  core_msg;
  logic [255:0] core_hash;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;

  g31_sha256_ctrl_if avs_if ();

  g31_sha256_ctrl dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .avs           (avs_if),
    .irq           (irq),
    .core_init     (core_init),
    .core_load     (core_load),
    .core_round_en (core_round_en),
    .core_t        (core_t),
    .core_msg      (core_msg),
    .core_update   (core_update),
    .core_hash     (core_hash)
  );

  always #5 clk_clk = ~clk_clk;

  // ---------------- behavioural SHA-256 datapath ----------------
  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic [31:0] hh [8];
  logic [31:0] va [8];
  logic [31:0] w  [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign core_hash = {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};

  always @(posedge clk_clk) begin
    logic [31:0] wt, t1, t2, s0, s1, ch, mj;
    int ti;
    if (core_update) upd_cnt++;
    if (core_init) for (int i = 0; i < 8; i++) hh[i] <= IV[i];
    if (core_load) for (int i = 0; i < 8; i++) va[i] <= hh[i];
    if (core_round_en) begin
      ti = int'(core_t);
      if (ti < 16) wt = core_msg;
      else begin
        s0 = rotr(w[ti-15], 7) ^ rotr(w[ti-15], 18) ^ (w[ti-15] >> 3);
        s1 = rotr(w[ti-2], 17) ^ rotr(w[ti-2], 19) ^ (w[ti-2] >> 10);
        wt = s1 + w[ti-7] + s0 + w[ti-16];
      end
      w[ti] <= wt;
      s1 = rotr(va[4], 6) ^ rotr(va[4], 11) ^ rotr(va[4], 25);
      ch = (va[4] & va[5]) ^ (~va[4] & va[6]);
      t1 = va[7] + s1 + ch + K[ti] + wt;
      s0 = rotr(va[0], 2) ^ rotr(va[0], 13) ^ rotr(va[0], 22);
      mj = (va[0] & va[1]) ^ (va[0] & va[2]) ^ (va[1] & va[2]);
      t2 = s0 + mj;
      va[7] <= va[6]; va[6] <= va[5]; va[5] <= va[4]; va[4] <= va[3] + t1;
      va[3] <= va[2]; va[2] <= va[1]; va[1] <= va[0]; va[0] <= t1 + t2;
    end
    if (core_update) for (int i = 0; i < 8; i++) hh[i] <= hh[i] + va[i];
  end

  // ---------------- checking helpers ----------------
  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk_clk);
    avs_if.avs_address   = addr;
    avs_if.avs_writedata = data;
    avs_if.avs_write     = 1'b1;
    @(negedge clk_clk);
    avs_if.avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    @(negedge clk_clk);
    avs_if.avs_address = addr;
    avs_if.avs_read    = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk_clk);
    avs_if.avs_read = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, avs_if.avs_readdata, e);
  endtask

  // Returns at the negedge where core_update is high.
  task automatic wait_update(input string tag);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_clk);
      if (core_update) found = 1;
    end
    chk({tag, "_timeout"}, 32'(found), 32'd1);
  endtask

  task automatic wait_t(input logic [5:0] tv, input string tag);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_clk);
      if (core_round_en && core_t == tv) found = 1;
    end
    chk({tag, "_timeout"}, 32'(found), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset_reset          = 1'b1;
    avs_if.avs_address   = '0;
    avs_if.avs_write     = 1'b0;
    avs_if.avs_writedata = '0;
    avs_if.avs_read      = 1'b0;
    repeat (3) @(negedge clk_clk);
    reset_reset = 1'b0;

    // Reset state.
    chk("rst_init", core_init, 0);
    chk("rst_load", core_load, 0);
    chk("rst_round_en", core_round_en, 0);
    chk("rst_update", core_update, 0);
    chk("rst_core_t", core_t, 0);
    chk("rst_irq", irq, 0);
    rd(5'h11, 32'h0, "rst_status");
    rd(5'h12, 32'h0, "unmapped");

    // "abc" block with timing check.
    wr(5'h00, 32'h61626380);
    for (int i = 1; i < 15; i++) wr(5'(i), 32'h0);
    wr(5'h0F, 32'h00000018);
    rd(5'h00, 32'h61626380, "m0_read");
    wr(5'h10, 32'h3);
    for (int c = 1; c <= 67; c++) begin
      chk($sformatf("init_c%0d", c), core_init, 32'(c == 1));
      chk($sformatf("load_c%0d", c), core_load, 32'(c == 2));
      chk($sformatf("round_en_c%0d", c), core_round_en, 32'(c >= 3 && c <= 66));
      chk($sformatf("update_c%0d", c), core_update, 32'(c == 67));
      if (c >= 3 && c <= 66) chk($sformatf("core_t_c%0d", c), core_t, 32'(c - 3));
      if (c == 3)  chk("msg_t0", core_msg, 32'h61626380);
      if (c == 18) chk("msg_t15", core_msg, 32'h00000018);
      @(negedge clk_clk);
    end
    chk("idle_round_en", core_round_en, 0);
    chk("idle_core_t", core_t, 0);
    rd(5'h11, 32'h00000102, "status_abc");
    rd(5'h18, 32'hBA7816BF, "h0_abc");
    rd(5'h1F, 32'hF20015AD, "h7_abc");

    // Start and buffer write while busy.
    base = upd_cnt;
    wr(5'h10, 32'h1);
    wait_t(6'd10, "ovr_wait");
    wr(5'h10, 32'h1);
    wr(5'h03, 32'hDEADBEEF);
    rd(5'h11, 32'h00000107, "status_busy");
    wait_update("ovr_upd");
    repeat (6) @(negedge clk_clk);
    chk("one_update", 32'(upd_cnt - base), 32'd1);
    rd(5'h03, 32'h0, "m3_kept");
    rd(5'h11, 32'h00000206, "status_ovr");
    wr(5'h11, 32'h6);
    rd(5'h11, 32'h00000200, "status_w1c");

    // irq, plus W1C of done in the UPDATE cycle.
    wr(5'h10, 32'h5);
    wait_update("irq_upd");
    avs_if.avs_address   = 5'h11;
    avs_if.avs_writedata = 32'h2;
    avs_if.avs_write     = 1'b1;
    chk("irq_upd_cycle", irq, 0);
    @(negedge clk_clk);
    avs_if.avs_write = 1'b0;
    chk("irq_done_cycle", irq, 0);
    @(negedge clk_clk);
    chk("irq_rise", irq, 1);
    rd(5'h11, 32'h00000302, "status_setwins");
    wr(5'h11, 32'h2);
    rd(5'h11, 32'h00000300, "status_clr");
    chk("irq_fall", irq, 0);

    // Reset mid-ROUND.
    wr(5'h10, 32'h1);
    wait_t(6'd30, "rst_wait");
    reset_reset = 1'b1;
    #1;
    chk("rst_mid_round_en", core_round_en, 0);
    chk("rst_mid_core_t", core_t, 0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    rd(5'h11, 32'h0, "status_after_rst");
    rd(5'h00, 32'h0, "m0_after_rst");
    chk("irq_after_rst", irq, 0);

    // 256 chained blocks: blkcnt wraps.
    for (int b = 0; b < 255; b++) begin
      wr(5'h10, 32'h1);
      wait_update("chain_upd");
      @(negedge clk_clk);
    end
    rd(5'h11, 32'h0000FF02, "status_blk255");
    wr(5'h10, 32'h1);
    wait_update("chain_last");
    @(negedge clk_clk);
    rd(5'h11, 32'h00000002, "status_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/g31_sha256_ctrl.md
Name: g31_sha256_ctrl

Overview:
Sequencer for the team's SHA-256 compression datapath. The HPS lightweight bridge drives it through an Avalon-MM slave register file. It holds one 16-word message block, runs the INIT/LOAD/64-round/UPDATE sequence on the external datapath, reports busy, done, overrun and a block count, and raises an interrupt. It sits between the HPS bridge and g31_sha256_core inside the g31_SHA256_system fabric.

Parameters:
ROUNDS, 64, number of compression rounds. Round index width is clog2(ROUNDS).
BLKCNT_W, 8, width of the processed-block counter.

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous, active-high reset
avs_address  in  5  word address
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_read  in  1  read strobe
avs_readdata  out  32  read data, valid one cycle after avs_read
irq  out  1  level interrupt
core_init  out  1  one-cycle pulse: datapath loads H0..H7 with the FIPS IV
core_load  out  1  one-cycle pulse: a..h <= H0..H7
core_round_en  out  1  high for exactly ROUNDS cycles
core_t  out  6  current round index
core_msg  out  32  M[core_t[3:0]], buffer word
core_update  out  1  one-cycle pulse: H[i] <= H[i] + working var
core_hash  in  256  H0 in [255:224] down to H7 in [31:0]

Behaviour:
- Register map (word addresses):
  - 0x00–0x0F: M0..M15, read/write.
  - 0x10 CTRL: bit0 start (write-1 pulse, reads 0), bit1 init_iv, bit2 irq_en.
  - 0x11 STATUS: bit0 busy, bit1 done (sticky, write 1 to clear), bit2 overrun (sticky, write 1 to clear), bits[15:8] blkcnt.
  - 0x18–0x1F: H0..H7 taken from core_hash.
  - Unmapped addresses read 0, writes ignored.
- Reads: avs_readdata is registered with 1-cycle latency. It holds its last value when avs_read is low. Reset value is 0.
- FSM states: IDLE, INIT, LOAD, ROUND, UPDATE.
  - IDLE -> INIT on an accepted start.
  - INIT: core_init=1 only if the latched init_iv=1, then LOAD.
  - LOAD: core_load=1, then ROUND.
  - ROUND: core_round_en=1, core_t counts 0..ROUNDS-1, one per cycle. After t=ROUNDS-1, go to UPDATE.
  - UPDATE: core_update=1, then IDLE.
- busy is 1 in every state except IDLE. The start write is accepted at cycle N and INIT is active at N+1. done is set at N+68, i.e. 67 busy cycles.
- core_msg = M[core_t[3:0]], combinational from the buffer. It is meaningful to the datapath for t<16 only; schedule expansion lives in the datapath.
- core_t is 0 outside ROUND.
- Start while busy: ignored and sets overrun. Write to M0..M15 while busy: ignored and sets overrun.
- init_iv and irq_en are latched from the CTRL write. init_iv=1 at start clears blkcnt to 0 before the block is processed.
- blkcnt increments in UPDATE and wraps 2^BLKCNT_W-1 -> 0.
- done is set on UPDATE->IDLE. Simultaneous set and W1C on done: set wins. A new start does not clear done; software clears it.
- irq = done & irq_en, registered.
- Reset (any cycle, including mid-ROUND): state goes to IDLE and all pulses drop immediately. Cleared to 0: core_t, busy, done, overrun, blkcnt, irq_en, init_iv, avs_readdata, M0..M15.

Optional Feature:
- Macro: G31_SHA_CTRL_DEBUG_EN.
- When defined: adds output port dbg_led[9:0] = {state code[2:0], core_t[5:0], busy}, registered, reset 0. State codes: IDLE=0, INIT=1, LOAD=2, ROUND=3, UPDATE=4. Intended to drive rled_export. Also adds STATUS bits[31:24] = count of ignored starts, saturating at 255.
- When undefined: no dbg_led port, and STATUS[31:24] reads 0.

Test Plan:
- Reset, then read 0x11 -> 0x00000000. All core_* outputs are 0.
- Write M0=0x61626380, M1..M14=0, M15=0x00000018, then CTRL=0x3 at cycle N:
  - core_init and core_load pulse at N+1 and N+2.
  - core_round_en is high for N+3..N+66, with core_msg=0x61626380 at t=0 and 0x18 at t=15.
  - core_update at N+67; STATUS reads 0x00000102 from N+68.
- With a behavioural datapath model on core_hash: after the "abc" block, reading 0x18 -> 0xBA7816BF and 0x1F -> 0xF20015AD.
- Write CTRL=0x1 and M3 mid-ROUND -> M3 unchanged, overrun=1, exactly one UPDATE. Write STATUS=0x6 -> done and overrun clear.
- CTRL=0x4 plus start -> irq rises the cycle after done. W1C of done in the same cycle UPDATE completes -> done stays 1.
- Assert reset_reset at t=30 of ROUND -> core_round_en drops immediately, and after release STATUS=0.
- 256 chained blocks with init_iv=0 -> blkcnt wraps to 0x00.
